multi_lane_unit: RTL

MULTI_LANE_UNIT -- requirements
Module: multi_lane_unit

---
 rtl/multi_lane_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/multi_lane_unit.sv
// Multi-lane multi-cycle unit: each lane captures an operand and finishes after its own delay.
// A single done pulse follows the slowest lane. Optional per-lane pulses: MULTI_LANE_UNIT_LANE_DONE_EN.

module multi_lane_lane #(
  parameter int LANE_W  = 32,
  parameter int DELAY_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_acc,
  input  logic [LANE_W-1:0]  i_data,
  input  logic [DELAY_W-1:0] i_dly,
  output logic [LANE_W-1:0]  o_data,
  output logic               o_fin,
  output logic               o_nxt_fin
);
  typedef enum logic {L_IDLE, L_RUN} lane_st_t;

  lane_st_t           r_state;
  logic [DELAY_W-1:0] r_dly;
  logic [DELAY_W-1:0] r_cnt;
  logic [LANE_W-1:0]  r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= L_IDLE;
      r_dly   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else if (i_acc) begin
      r_state <= L_RUN;
      r_dly   <= i_dly;
      r_cnt   <= '0;
      r_data  <= i_data;
    end else if (r_state == L_RUN) begin
      if (o_fin) r_state <= L_IDLE;
      else       r_cnt   <= r_cnt + DELAY_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_fin  = (r_state == L_RUN) && (r_cnt == r_dly);
  // Lane will be finished or idle in the next cycle; lets the top FSM land in DONE exactly on time.
  assign o_nxt_fin = i_acc ? (i_dly == '0)
                           : ((r_state == L_IDLE) || o_fin || ((r_cnt + DELAY_W'(1)) == r_dly));
endmodule

module multi_lane_unit #(
  parameter int LANES   = 2,
  parameter int LANE_W  = 32,
  parameter int DELAY_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LANES*LANE_W-1:0]   inp,
  input  logic [LANES*DELAY_W-1:0]  delay,
  output logic                      busy,
  output logic                      done,
`ifdef MULTI_LANE_UNIT_LANE_DONE_EN
  output logic [LANES-1:0]          lane_done,
`endif
  output logic [LANES*LANE_W-1:0]   out
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_st_t;

  top_st_t                       r_state;
  logic                          r_arm;
  logic                          w_acc;
  logic                          w_all_nxt;
  logic [LANES-1:0]              w_fin;
  logic [LANES-1:0]              w_nxt_fin;
  logic [LANES-1:0][LANE_W-1:0]  w_data;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      multi_lane_lane #(.LANE_W(LANE_W), .DELAY_W(DELAY_W)) u_lane (
        .clock     (clock),
        .reset     (reset),
        .i_acc     (w_acc),
        .i_data    (inp[gi*LANE_W +: LANE_W]),
        .i_dly     (delay[gi*DELAY_W +: DELAY_W]),
        .o_data    (w_data[gi]),
        .o_fin     (w_fin[gi]),
        .o_nxt_fin (w_nxt_fin[gi])
      );
    end
  endgenerate

  // r_arm blocks acceptance on the first edge after reset release.
  assign w_acc     = start && r_arm && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_all_nxt = &w_nxt_fin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_arm   <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        S_IDLE:  if (w_acc) r_state <= w_all_nxt ? S_DONE : S_RUN;
        S_RUN:   if (w_all_nxt) r_state <= S_DONE;
        S_DONE:  r_state <= w_acc ? (w_all_nxt ? S_DONE : S_RUN) : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done = (r_state == S_DONE);
  assign busy = (r_state != S_IDLE);
  assign out  = done ? w_data : '0;
`ifdef MULTI_LANE_UNIT_LANE_DONE_EN
  assign lane_done = w_fin;
`endif
endmodule
